// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  localparam int   DEFAULT_DATA_WIDTH = 8;
  localparam logic LINE_IDLE          = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Bit-index width; a one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer for uart_tx: state register, data bit index and next-state logic.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int  CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              data_valid,
  input  logic              par_en,
  output uart_state_e       state,
  output logic [CNT_W-1:0]  bit_idx
);

  // Exact match on the last index, so the counter never relies on wrapping.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  uart_state_e      state_reg, state_next;
  logic [CNT_W-1:0] bit_idx_reg, bit_idx_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    case (state_reg)
      IDLE: begin
        bit_idx_next = '0;
        if (data_valid) begin
          state_next = START;
        end
      end
      START: begin
        state_next   = DATA;
        bit_idx_next = '0;
      end
      DATA: begin
        if (bit_idx_reg == LAST_IDX) begin
          state_next   = par_en ? PARITY : STOP;
          bit_idx_next = '0;
        end else begin
          bit_idx_next = bit_idx_reg + 1'b1;
        end
      end
      PARITY: state_next = STOP;
      STOP:   state_next = IDLE;
      default: begin
        state_next   = IDLE;
        bit_idx_next = '0;
      end
    endcase
  end

  assign state   = state_reg;
  assign bit_idx = bit_idx_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter running at one bit per CLK: start, LSB-first data, optional parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic START_BIT  = 1'b0,
  parameter logic STOP_BIT   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  uart_state_e           state;
  logic [CNT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  accept;

  assign accept = (state == IDLE) && DATA_VALID;

  uart_tx_fsm #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fsm (
    .clk        (CLK),
    .srst       (RST),
    .data_valid (DATA_VALID),
    .par_en     (par_en_reg),
    .state      (state),
    .bit_idx    (bit_idx)
  );

  // Frame parameters are captured once and held until the next accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
    end else if (accept) begin
      data_reg    <= P_DATA;
      par_en_reg  <= PAR_EN;
      par_typ_reg <= PAR_TYP;
    end
  end

  // The line lags the state by one edge, which keeps both outputs registered.
  always_comb begin
    tx_next   = LINE_IDLE;
    busy_next = 1'b1;
    case (state)
      IDLE:    busy_next = 1'b0;
      START:   tx_next   = START_BIT;
      DATA:    tx_next   = data_reg[bit_idx];
      PARITY:  tx_next   = (^data_reg) ^ par_typ_reg;
      STOP:    tx_next   = STOP_BIT;
      default: busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_reg   <= LINE_IDLE;
      busy_reg <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
    end
  end

  assign TX_OUT = tx_reg;
  assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at the default 8-bit width.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int passed = 0;

  logic [1:24] cap_tx;
  logic [1:24] cap_busy;
  logic [1:24] exp_tx;
  logic [1:24] exp_busy;

  always #5 CLK = ~CLK;

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Presents one word, then records TX_OUT/Busy after each of the 24 edges
  // following the accepting edge (sample j belongs to edge k+j).
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input bit hold, input bit perturb);
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    if (!hold) DATA_VALID = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge CLK);
      cap_tx[j] = TX_OUT;
      cap_busy[j] = Busy;
      if (perturb && j == 3) begin
        P_DATA = ~d;
        PAR_EN = ~pe;
        PAR_TYP = ~pt;
      end
    end
    DATA_VALID = 1'b0;
    PAR_EN = pe;
    PAR_TYP = pt;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DATA_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0)
        $display("FAIL reset_hold[%0d]: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", i, TX_OUT, Busy);
      else passed++;
    end
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0)
        $display("FAIL idle_after_reset[%0d]: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", i, TX_OUT, Busy);
      else passed++;
    end
  endtask

  task automatic test_reset_override();
    @(negedge CLK);
    RST = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA = 8'hFF;
    PAR_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0)
        $display("FAIL reset_override[%0d]: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", i, TX_OUT, Busy);
      else passed++;
    end
    DATA_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      $display("FAIL reset_override_release: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    else passed++;
  endtask

  task automatic test_even_parity();
    run_frame(8'hE1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_tx   = {11'b0_10000111_0_1, 13'h1FFF};
    exp_busy = {11'h7FF, 13'h0000};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL even_parity_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
    checks++;
    if (cap_busy !== exp_busy)
      $display("FAIL even_parity_busy: got %b expected %b", cap_busy, exp_busy);
    else passed++;
  endtask

  task automatic test_odd_parity();
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_tx   = {11'b0_11111111_1_1, 13'h1FFF};
    exp_busy = {11'h7FF, 13'h0000};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL odd_parity_ff_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
    checks++;
    if (cap_busy !== exp_busy)
      $display("FAIL odd_parity_ff_busy: got %b expected %b", cap_busy, exp_busy);
    else passed++;

    run_frame(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_tx = {11'b0_00000001_1_1, 13'h1FFF};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL even_parity_80_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;

    run_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_tx = {11'b0_00000001_0_1, 13'h1FFF};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL odd_parity_80_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
  endtask

  task automatic test_no_parity();
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_tx   = {10'b0_11111111_1, 14'h3FFF};
    exp_busy = {10'h3FF, 14'h0000};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL no_parity_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
    checks++;
    if (cap_busy !== exp_busy)
      $display("FAIL no_parity_busy: got %b expected %b", cap_busy, exp_busy);
    else passed++;
  endtask

  task automatic test_mid_frame_change();
    run_frame(8'hE1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_tx   = {11'b0_10000111_0_1, 13'h1FFF};
    exp_busy = {11'h7FF, 13'h0000};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL mid_frame_change_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
    checks++;
    if (cap_busy !== exp_busy)
      $display("FAIL mid_frame_change_busy: got %b expected %b", cap_busy, exp_busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_frame(8'hE1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_tx   = {11'b0_10000111_0_1, 1'b1, 11'b0_10000111_0_1, 1'b1};
    exp_busy = {11'h7FF, 1'b0, 11'h7FF, 1'b0};
    checks++;
    if (cap_tx !== exp_tx)
      $display("FAIL back_to_back_tx: got %b expected %b", cap_tx, exp_tx);
    else passed++;
    checks++;
    if (cap_busy !== exp_busy)
      $display("FAIL back_to_back_busy: got %b expected %b", cap_busy, exp_busy);
    else passed++;
  endtask

  task automatic test_reset_mid_data();
    @(negedge CLK);
    P_DATA = 8'h00;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0 || Busy !== 1'b1)
      $display("FAIL mid_data_before_reset: TX_OUT=%b Busy=%b expected TX_OUT=0 Busy=1", TX_OUT, Busy);
    else passed++;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      $display("FAIL reset_mid_data: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    else passed++;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      $display("FAIL idle_after_abort: TX_OUT=%b Busy=%b expected TX_OUT=1 Busy=0", TX_OUT, Busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_override();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_mid_frame_change();
    test_back_to_back();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
